// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: shared prescaled period counter (edge- or center-aligned),
// per-channel double-buffered duty registers that update only at period boundaries.
module pwm_multi_channel #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                mode,
  input  logic                wr_en,
  input  logic [3:0]          wr_ch,
  input  logic [WIDTH-1:0]    wr_duty,
  input  logic [CHANNELS-1:0] invert,
  output logic [CHANNELS-1:0] pwm,
  output logic                period_start
);

  localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] MAX       = '1;
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

  logic [PW-1:0]                     presc_q, presc_d;
  logic [WIDTH-1:0]                  cnt_q, cnt_d;
  dir_t                              dir_q, dir_d;
  logic                              mode_q, mode_d;
  logic [CHANNELS-1:0][WIDTH-1:0]    shadow_q, shadow_d;
  logic [CHANNELS-1:0][WIDTH-1:0]    duty_q, duty_d;
  logic [CHANNELS-1:0]               pwm_q, pwm_d;
  logic                              ps_q, ps_d;
  logic                              tick;
  logic                              boundary;
  logic [CHANNELS-1:0]               raw;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    mode_d   = mode_q;
    shadow_d = shadow_q;
    duty_d   = duty_q;
    tick     = 1'b0;
    boundary = 1'b0;
    raw      = '0;

    if (enable) begin
      tick    = (presc_q == PRESC_LAST);
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    if (tick) begin
      if (!mode_q) begin
        cnt_d    = cnt_q + 1'b1;
        boundary = (cnt_q == MAX);
      end else if (dir_q == UP) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == MAX - ONE) dir_d = DOWN;
      end else begin
        cnt_d    = cnt_q - 1'b1;
        boundary = (cnt_q == ONE);
      end
    end

    // Boundary takes the shadow as it stood before any same-cycle write.
    if (boundary) begin
      duty_d = shadow_q;
      mode_d = mode;
      dir_d  = UP;
    end

    for (int i = 0; i < CHANNELS; i++) begin
      if (wr_en && (wr_ch == 4'(i))) shadow_d[i] = wr_duty;
      raw[i] = (cnt_q < duty_q[i]);
    end

    pwm_d = raw ^ invert;
    ps_d  = boundary;
  end

  always_ff @(posedge clk) begin
    // NOTE: the duty register arrays are small flop banks, so they are cleared with everything else.
    if (reset) begin
      presc_q  <= '0;
      cnt_q    <= '0;
      dir_q    <= UP;
      mode_q   <= 1'b0;
      shadow_q <= '0;
      duty_q   <= '0;
      pwm_q    <= '0;
      ps_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      mode_q   <= mode_d;
      shadow_q <= shadow_d;
      duty_q   <= duty_d;
      pwm_q    <= pwm_d;
      ps_q     <= ps_d;
    end
  end

  assign pwm          = pwm_q;
  assign period_start = ps_q;

endmodule
